// File: rtl/tdp_ram_pkg.sv
// Shared types and elaboration helpers for the byte-enable true dual-port RAM.
package tdp_ram_pkg;

  // Same-port read-during-write behaviour.
  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  // Clear engine states.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  // Number of byte-enable lanes in a word.
  function automatic int calc_nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Geometry sanity: whole lanes per word and at least two words.
  function automatic bit cfg_ok(input int data_w, input int byte_w, input int depth);
    return (byte_w > 0) && (data_w % byte_w == 0) && (depth >= 2);
  endfunction

endpackage

// File: rtl/tdp_ram_be_init_if.sv
// One RAM access port: enable, byte write enables, address, data in/out, read strobe.
interface tdp_ram_be_init_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NB         = 4
) ();
  logic                  en;
  logic [NB-1:0]         we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;

  modport master (output en, we, addr, din, input dout, dout_vld);
  modport slave  (input en, we, addr, din, output dout, dout_vld);
endinterface

// File: rtl/tdp_ram_clear_fsm.sv
// Sequential clear engine: walks every address once, one word per clock.
module tdp_ram_clear_fsm
  import tdp_ram_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  init_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  localparam logic [0:0]            S_CLEAR = CLEAR;
  localparam logic [0:0]            S_IDLE  = IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0] state;

  // Clear walk; reset (or a request from idle) restarts it at address 0.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_addr == LAST) begin
            state    <= S_IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        S_IDLE: begin
          if (init_req) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          state    <= S_CLEAR;
          clr_addr <= '0;
        end
      endcase
    end
  end

  // busy tracks the state directly, so it drops on the edge that leaves CLEAR.
  assign busy   = (state != S_IDLE);
  assign clr_we = (state == S_CLEAR);

endmodule

// File: rtl/tdp_ram_be_init.sv
// Common-clock true dual-port RAM with byte enables, sequential clear,
// selectable read-during-write and a cross-port collision flag.
module tdp_ram_be_init
  import tdp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter int                    BYTE_W     = 8,
  parameter int                    RDW_MODE   = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             init_req,
  output logic             busy,
  output logic             collision,
  tdp_ram_be_init_if.slave pa,
  tdp_ram_be_init_if.slave pb
);
  localparam int NB     = calc_nb(DATA_WIDTH, BYTE_W);
  localparam int NP     = 2;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  if (!cfg_ok(DATA_WIDTH, BYTE_W, DEPTH)) begin : g_bad_geom
    $error("tdp_ram_be_init: DATA_WIDTH must be a multiple of BYTE_W and DEPTH >= 2");
  end
  if (RDW_MODE < 0 || RDW_MODE > 1 || OUT_REG < 0 || OUT_REG > 1) begin : g_bad_mode
    $error("tdp_ram_be_init: RDW_MODE and OUT_REG must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  // Index 0 is port A, index 1 is port B.
  logic [NP-1:0]                 en, in_rng, acc, wr, vld;
  logic [NP-1:0][NB-1:0]         we, lane_wr;
  logic [NP-1:0][ADDR_WIDTH-1:0] addr;
  logic [NP-1:0][DATA_WIDTH-1:0] din, old, merged, rdat, dout;
  logic [NB-1:0]                 b_lane_wr;
  logic                          same_addr, coll_d;

  tdp_ram_clear_fsm #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr (
    .clka     (clka),
    .rsta     (rsta),
    .init_req (init_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign en   = {pb.en,   pa.en};
  assign we   = {pb.we,   pa.we};
  assign addr = {pb.addr, pa.addr};
  assign din  = {pb.din,  pa.din};

  assign pa.dout     = dout[0];
  assign pa.dout_vld = vld[0];
  assign pb.dout     = dout[1];
  assign pb.dout_vld = vld[1];

  // Per-port decode: acceptance, range check, lane writes and read word.
  always_comb begin
    in_rng  = '0;
    acc     = '0;
    wr      = '0;
    old     = '0;
    lane_wr = '0;
    merged  = '0;
    rdat    = '0;
    for (int p = 0; p < NP; p++) begin
      in_rng[p] = 32'(addr[p]) < 32'(DEPTH);
      acc[p]    = en[p] & ~busy;
      wr[p]     = acc[p] & in_rng[p] & (|we[p]);
      old[p]    = in_rng[p] ? mem[addr[p]] : '0;
      for (int k = 0; k < NB; k++) begin
        lane_wr[p][k] = wr[p] & we[p][k];
        merged[p][k*BYTE_W +: BYTE_W] = lane_wr[p][k] ? din[p][k*BYTE_W +: BYTE_W]
                                                      : old[p][k*BYTE_W +: BYTE_W];
      end
      // Own-port merge only; a word written by the other port is always seen old.
      rdat[p] = (RDW_MODE == int'(WRITE_FIRST)) ? merged[p] : old[p];
    end
  end

  // Cross-port conflict: port A owns every lane it writes at a shared address.
  assign same_addr = acc[0] & acc[1] & in_rng[0] & (addr[0] == addr[1]);
  assign coll_d    = same_addr & (wr[0] | wr[1]);
  assign b_lane_wr = lane_wr[1] & ~({NB{same_addr}} & lane_wr[0]);

  // Array write: clear engine has priority, ports are idle while it runs.
  always_ff @(posedge clka) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (b_lane_wr[k])
          mem[addr[1]][k*BYTE_W +: BYTE_W] <= din[1][k*BYTE_W +: BYTE_W];
        if (lane_wr[0][k])
          mem[addr[0]][k*BYTE_W +: BYTE_W] <= din[0][k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Collision pulse, one cycle after the offending accesses.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) collision <= 1'b0;
    else      collision <= coll_d;
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [STAGES:1]                 vld_q;
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

    assign vld_pipe = {vld_q, acc[p]};

    // Read pipeline: data stages only load behind a valid, so dout holds between reads.
    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        vld_q    <= '0;
        dat_pipe <= '0;
      end else begin
        vld_q <= vld_pipe[STAGES-1:0];
        if (acc[p]) dat_pipe[1] <= rdat[p];
        for (int s = 2; s <= STAGES; s++)
          if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end

    assign dout[p] = dat_pipe[STAGES];
    assign vld[p]  = vld_q[STAGES];
  end

endmodule

// File: tb/tb_tdp_ram_be_init.sv
// Directed bench: three RAM instances share one stimulus stream
// (u0 default, u1 WRITE_FIRST, u2 OUT_REG=1/DEPTH=48/INIT_VAL=C0DE0000).
module tb_tdp_ram_be_init;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NB = 4;

  logic          clka = 1'b0, rsta = 1'b0, init_req = 1'b0;
  logic          en_a = 1'b0, en_b = 1'b0;
  logic [NB-1:0] we_a = '0, we_b = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic          busy0, busy1, busy2, col0, col1, col2;
  int            total = 0, bad = 0;
  int            n0, n2, vbad;

  always #5 clka = ~clka;

  tdp_ram_be_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB(NB)) a0 (), b0 (), a1 (), b1 (), a2 (), b2 ();

  assign a0.en = en_a; assign a0.we = we_a; assign a0.addr = addr_a; assign a0.din = din_a;
  assign b0.en = en_b; assign b0.we = we_b; assign b0.addr = addr_b; assign b0.din = din_b;
  assign a1.en = en_a; assign a1.we = we_a; assign a1.addr = addr_a; assign a1.din = din_a;
  assign b1.en = en_b; assign b1.we = we_b; assign b1.addr = addr_b; assign b1.din = din_b;
  assign a2.en = en_a; assign a2.we = we_a; assign a2.addr = addr_a; assign a2.din = din_a;
  assign b2.en = en_b; assign b2.we = we_b; assign b2.addr = addr_b; assign b2.din = din_b;

  tdp_ram_be_init u0 (.clka(clka), .rsta(rsta), .init_req(init_req), .busy(busy0),
                      .collision(col0), .pa(a0), .pb(b0));
  tdp_ram_be_init #(.RDW_MODE(1)) u1 (.clka(clka), .rsta(rsta), .init_req(init_req),
                      .busy(busy1), .collision(col1), .pa(a1), .pb(b1));
  tdp_ram_be_init #(.DEPTH(48), .OUT_REG(1), .INIT_VAL(32'hC0DE_0000)) u2 (.clka(clka),
                      .rsta(rsta), .init_req(init_req), .busy(busy2), .collision(col2),
                      .pa(a2), .pb(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  // One access cycle on both ports, then both ports idle again.
  task automatic acc(input logic ea, input logic [3:0] wa, input logic [5:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [5:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    cyc();
    en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0;
  endtask

  task automatic count_busy(output int c0, output int c2);
    c0 = 0; c2 = 0;
    for (int i = 0; i < 200 && (busy0 || busy2); i++) begin
      if (busy0) c0++;
      if (busy2) c2++;
      cyc();
    end
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'h0101_0101 * (k + 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rsta is high.
    #1 rsta = 1'b1;
    #2;
    chk("rst_busy", busy0, 1);
    chk("rst_douta", a0.dout, 0);
    chk("rst_vld", {a0.dout_vld, b0.dout_vld, a2.dout_vld}, 0);
    chk("rst_col", col0, 0);
    repeat (3) @(posedge clka);
    #1 rsta = 1'b0;

    // Clear after reset: exactly DEPTH busy cycles.
    count_busy(n0, n2);
    chk("boot_busy64", n0, 64);
    chk("boot_busy48", n2, 48);
    chk("boot_busy_u1", busy1, 0);

    // Every word reads back zero, vld one cycle after each enable.
    for (int k = 0; k < 64; k++) begin
      acc(1, 4'h0, 6'(k), 0, 1, 4'h0, 6'(63 - k), 0);
      chk("init_douta", a0.dout, 0);
      chk("init_doutb", b0.dout, 0);
      chk("init_vld", {a0.dout_vld, b0.dout_vld}, 2'b11);
    end
    cyc();
    chk("vld_one_cycle", {a0.dout_vld, b0.dout_vld}, 0);

    // Byte-enable write and same-port read-during-write.
    acc(1, 4'hF, 5, 32'h1122_3344, 0, 0, 0, 0);
    acc(1, 4'b0101, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("rdw_read_first", a0.dout, 32'h1122_3344);
    chk("rdw_write_first", a1.dout, 32'h11AD_33EF);
    chk("rdw_vld", a0.dout_vld, 1);
    acc(0, 0, 0, 0, 1, 4'h0, 5, 0);
    chk("be_merge_u0", b0.dout, 32'h11AD_33EF);
    chk("be_merge_u1", b1.dout, 32'h11AD_33EF);
    acc(1, 4'h0, 5, 0, 1, 4'h0, 5, 0);
    chk("two_reads_no_col", col0, 0);

    // Both ports write the same address: A owns its lanes.
    acc(1, 4'b0011, 9, 32'hAAAA_AAAA, 1, 4'hF, 9, 32'hBBBB_BBBB);
    chk("ww_col_pulse", col0, 1);
    cyc();
    chk("ww_col_drop", col0, 0);
    acc(1, 4'h0, 9, 0, 0, 0, 0, 0);
    chk("ww_data_u0", a0.dout, 32'hBBBB_AAAA);
    chk("ww_data_u1", a1.dout, 32'hBBBB_AAAA);

    // A writes, B reads the same address: B sees the old word in both modes.
    acc(1, 4'hF, 3, 32'h1234_5678, 1, 4'h0, 3, 0);
    chk("wr_rd_old_u0", b0.dout, 0);
    chk("wr_rd_old_u1", b1.dout, 0);
    chk("wr_rd_col", col0, 1);
    chk("wr_rd_own_wf", a1.dout, 32'h1234_5678);
    acc(0, 0, 0, 0, 1, 4'h0, 3, 0);
    chk("wr_rd_new", b0.dout, 32'h1234_5678);

    // Different addresses written together: no collision.
    acc(1, 4'hF, 20, 32'h0000_0020, 1, 4'hF, 21, 32'h0000_0021);
    chk("diff_addr_no_col", col0, 0);
    acc(1, 4'h0, 21, 0, 1, 4'h0, 20, 0);
    chk("diff_addr_a", a0.dout, 32'h0000_0021);
    chk("diff_addr_b", b0.dout, 32'h0000_0020);

    // Fill, then clear on request with reads attempted throughout.
    for (int k = 0; k < 32; k++)
      acc(1, 4'hF, 6'(2 * k), pat(2 * k), 1, 4'hF, 6'(2 * k + 1), pat(2 * k + 1));
    acc(1, 4'h0, 10, 0, 1, 4'h0, 63, 0);
    chk("fill_a10", a0.dout, 32'h0B0B_0B0B);
    chk("fill_b63", b0.dout, 32'h4040_4040);
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    en_a = 1'b1; we_a = '0; addr_a = 7;
    n0 = 0; vbad = 0;
    while (busy0 && n0 < 200) begin
      if (a0.dout_vld) vbad++;
      init_req = (n0 == 30);
      n0++;
      cyc();
    end
    init_req = 1'b0;
    if (a0.dout_vld) vbad++;
    en_a = 1'b0;
    chk("req_busy64", n0, 64);
    chk("busy_no_vld", vbad, 0);
    chk("busy_dout_hold", a0.dout, 32'h0B0B_0B0B);
    for (int k = 0; k < 64; k++) begin
      acc(1, 4'h0, 6'(k), 0, 1, 4'h0, 6'(63 - k), 0);
      chk("clr_douta", a0.dout, 0);
      chk("clr_doutb", b0.dout, 0);
    end

    // Reset in the middle of a clear restarts it from address 0.
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    repeat (20) cyc();
    rsta = 1'b1;
    #2;
    chk("midclr_rst_busy", busy0, 1);
    chk("midclr_rst_dout", a0.dout, 0);
    cyc();
    rsta = 1'b0;
    count_busy(n0, n2);
    chk("restart_busy64", n0, 64);
    chk("restart_busy48", n2, 48);

    // Output register, non-power-of-two depth, out-of-range addresses.
    acc(1, 4'h0, 47, 0, 0, 0, 0, 0);
    chk("oreg_lat1_vld", a2.dout_vld, 0);
    chk("oreg_lat1_dout", a2.dout, 0);
    cyc();
    chk("oreg_lat2_dout", a2.dout, 32'hC0DE_0000);
    chk("oreg_lat2_vld", a2.dout_vld, 1);
    cyc();
    chk("oreg_vld_drop", a2.dout_vld, 0);
    acc(1, 4'h0, 50, 0, 0, 0, 0, 0);
    cyc();
    chk("oor_rd_zero", a2.dout, 0);
    chk("oor_rd_vld", a2.dout_vld, 1);
    acc(1, 4'hF, 2, 32'h5555_AAAA, 0, 0, 0, 0);
    acc(1, 4'hF, 50, 32'hFFFF_FFFF, 0, 0, 0, 0);
    acc(1, 4'h0, 2, 0, 0, 0, 0, 0);
    cyc();
    chk("oor_wr_no_alias", a2.dout, 32'h5555_AAAA);
    acc(1, 4'h0, 50, 0, 0, 0, 0, 0);
    cyc();
    chk("oor_wr_dropped", a2.dout, 0);

    // Reset with a read in flight flushes the output stages.
    acc(1, 4'h0, 47, 0, 0, 0, 0, 0);
    rsta = 1'b1;
    #2 rsta = 1'b0;
    cyc();
    chk("flush_vld", a2.dout_vld, 0);
    chk("flush_dout", a2.dout, 0);
    chk("flush_busy", busy2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
